prog_loader: RTL and testbench

Program loader for the 16-bit SAP computer. Before the CPU runs, it takes a byte stream from the host or programming interface and packs it into 16-bit words, high byte first. It writes each word into main RAM at consecutive addresses from 0. It drives the RAM's address, data and write-enable inputs directly, and holds address and data stable around every write pulse.

---
 rtl/sap_pkg.sv | 17 +
 rtl/prog_loader.sv | 88 ++++++++
 tb/tb_prog_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared state encoding and bus widths for the SAP program loader
package sap_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        SETUP,
        WRITE,
        HOLD,
        DONE
    } load_state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - packs a host byte stream into 16-bit words and writes them to RAM from address 0
module prog_loader
    import sap_pkg::*;
#(
    parameter int LOAD_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [WORD_W-1:0] addr,
    output logic [WORD_W-1:0] bus,
    output logic              ram_write,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] word_count
);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LOAD_WORDS - 1);

    load_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            addr       <= '0;
            bus        <= '0;
            ram_write  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            ram_write <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr       <= '0;
                        word_count <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        state      <= GET_HI;
                    end
                end
                GET_HI: begin
                    if (byte_valid) begin
                        bus[WORD_W-1:BYTE_W] <= byte_in;
                        state                <= GET_LO;
                    end
                end
                GET_LO: begin
                    if (byte_valid) begin
                        bus[BYTE_W-1:0] <= byte_in;
                        byte_ready      <= 1'b0;
                        state           <= SETUP;
                    end
                end
                // Strobe is raised on the edge entering WRITE so it lasts exactly that state.
                SETUP: begin
                    ram_write <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    word_count <= word_count + 16'd1;
                    if (word_count == LAST_WORD) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        addr       <= addr + 16'd1;
                        byte_ready <= 1'b1;
                        state      <= GET_HI;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a word-level model
module tb_prog_loader;

    localparam int LW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] addr;
    logic [15:0] bus;
    logic        ram_write;
    logic        busy;
    logic        done;
    logic [15:0] word_count;

    prog_loader #(.LOAD_WORDS(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .addr       (addr),
        .bus        (bus),
        .ram_write  (ram_write),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Word-level model: a load is active, some bytes of the current word are in,
    // and after the second byte three fixed cycles (setup, strobe, hold) elapse.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    logic [15:0] m_addr   = '0;
    logic [15:0] m_bus    = '0;
    int          m_wc     = 0;
    int          m_nb     = 0;
    int          m_tail   = 0;

    logic [15:0] exp_ram [LW];
    logic [15:0] dut_ram [LW];

    function automatic bit exp_ready();
        return m_active && (m_nb < 2);
    endfunction

    function automatic bit exp_write();
        return m_active && (m_nb == 2) && (m_tail == 2);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_addr = '0; m_bus = '0;
            m_wc = 0; m_nb = 0; m_tail = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_done = 1'b0; m_addr = '0;
                m_wc = 0; m_nb = 0; m_tail = 0;
            end
        end else if (m_nb < 2) begin
            if (byte_valid) begin
                if (m_nb == 0) m_bus[15:8] = byte_in;
                else           m_bus[7:0]  = byte_in;
                m_nb++;
                if (m_nb == 2) m_tail = 1;
            end
        end else if (m_tail < 3) begin
            m_tail++;
        end else begin
            m_wc++;
            m_nb = 0;
            m_tail = 0;
            if (m_wc == LW) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else begin
                m_addr++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready", byte_ready, exp_ready());
            chk("ram_write", ram_write, exp_write());
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("addr", addr, m_addr);
            chk("bus", bus, m_bus);
            chk("word_count", word_count, 16'(m_wc));
            if (exp_write()) exp_ram[m_addr[3:0]] = m_bus;
            if (ram_write === 1'b1 && addr < 16'(LW)) dut_ram[addr[3:0]] = bus;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        int  n;
        bit  r;
        n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        do begin
            r = exp_ready();
            tick();
            n++;
        end while (!r && n < 100);
        if (!r) chk("feed_timeout", 16'd1, 16'd0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 16'd1, 16'd0);
    endtask

    task automatic compare_ram(input string tag);
        for (int i = 0; i < LW; i++) chk(tag, dut_ram[i], exp_ram[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int c0;
        int n;
        int gap_writes;

        for (int i = 0; i < LW; i++) begin
            exp_ram[i] = '0;
            dut_ram[i] = '0;
        end
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_addr", addr, 16'h0000);
        chk("reset_busy", busy, 16'h0000);
        rst = 1'b0;

        // valid in IDLE is ignored, also in the start cycle; start in GET_LO is ignored
        byte_in = 8'hEE;
        byte_valid = 1'b1;
        repeat (3) tick();
        chk("idle_ready", byte_ready, 16'h0000);
        pulse_start();
        feed(8'h12);
        start = 1'b1;
        feed(8'h34);
        start = 1'b0;
        chk("setup_we", ram_write, 16'h0000);
        chk("setup_addr", addr, 16'h0000);
        chk("setup_bus", bus, 16'h1234);
        tick();
        chk("write_we", ram_write, 16'h0001);
        chk("write_bus", bus, 16'h1234);
        tick();
        chk("hold_we", ram_write, 16'h0000);
        chk("hold_addr", addr, 16'h0000);
        chk("hold_bus", bus, 16'h1234);
        for (int i = 2; i < 2 * LW; i++) feed(8'($urandom));
        wait_done(n);
        chk("strobe_word0", dut_ram[0], 16'h1234);
        compare_ram("ram_first");

        // full load 0x00..0x1F with valid held high
        pulse_start();
        c0 = cyc;
        for (int i = 0; i < 2 * LW; i++) feed(8'(i));
        wait_done(n);
        chk("done_cycle", 16'(cyc - c0), 16'd80);
        chk("full_count", word_count, 16'd16);
        chk("full_word2", dut_ram[2], 16'h0405);
        chk("full_word15", dut_ram[15], 16'h1E1F);
        compare_ram("ram_full");

        // reload from DONE
        byte_valid = 1'b0;
        pulse_start();
        chk("reload_done", done, 16'h0000);
        chk("reload_count", word_count, 16'h0000);
        for (int i = 0; i < 2 * LW; i++) feed(8'($urandom));
        wait_done(n);
        compare_ram("ram_reload");

        // host stall between high and low byte
        pulse_start();
        feed(8'hAB);
        byte_valid = 1'b0;
        gap_writes = 0;
        repeat (10) begin
            tick();
            if (ram_write !== 1'b0) gap_writes++;
        end
        chk("stall_no_write", 16'(gap_writes), 16'd0);
        feed(8'hCD);
        byte_valid = 1'b0;
        repeat (3) tick();
        chk("stall_word0", dut_ram[0], 16'hABCD);

        // reset during the strobe of word 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) feed(8'($urandom));
        byte_valid = 1'b0;
        tick();
        chk("pre_rst_we", ram_write, 16'h0001);
        chk("pre_rst_addr", addr, 16'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_we", ram_write, 16'h0000);
        chk("rst_addr", addr, 16'h0000);
        chk("rst_bus", bus, 16'h0000);
        chk("rst_busy", busy, 16'h0000);
        chk("rst_count", word_count, 16'h0000);
        pulse_start();
        chk("restart_addr", addr, 16'h0000);
        chk("restart_busy", busy, 16'h0001);

        // randomized loads: random valid, random byte_in, stray start pulses
        for (int l = 0; l < 3; l++) begin
            if (l > 0) pulse_start();
            n = 0;
            while (!m_done && n < 3000) begin
                byte_in    = 8'($urandom);
                byte_valid = ($urandom_range(0, 9) < 6);
                start      = ($urandom_range(0, 7) == 0) && m_active;
                tick();
                n++;
            end
            start = 1'b0;
            byte_valid = 1'b0;
            if (!m_done) chk("random_timeout", 16'd1, 16'd0);
            tick();
            compare_ram("ram_random");
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
